// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: memory request/response side plus controller delivery side.
interface fetch_unit_if;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic [31:0] IRData;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;

  modport master (
    output IReq, IAddr, Instr, InstrPC, InstrValid,
    input  IAck, IRData, PCSrc, BranchTarget, InstrReady
  );

  modport slave (
    input  IReq, IAddr, Instr, InstrPC, InstrValid,
    output IAck, IRData, PCSrc, BranchTarget, InstrReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher with a 2-entry in-order queue and redirect/drop handling.
// Define FETCH_BYPASS_EN to forward a response to Instr in its IAck cycle when the queue is empty.
module fetch_unit (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [1:0][31:0] q_data;
  logic [1:0][31:0] q_pc;
  logic [1:0]      count;
  logic            ack_ok, push, pop, issue;
  logic [31:0]     redir_pc;

  assign redir_pc = {bus.BranchTarget[31:2], 2'b00};
  // Only a response in WAIT without a same-cycle redirect is kept.
  assign ack_ok   = (state == WAIT) && bus.IAck && !bus.PCSrc;
  // IDLE means nothing outstanding, so count alone bounds the issue.
  assign issue    = (state == IDLE) && !bus.PCSrc && (count < 2'd2);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass         = ack_ok && (count == 2'd0);
  assign bus.InstrValid = (count != 2'd0) || bypass;
  assign bus.Instr      = bypass ? bus.IRData : q_data[0];
  assign bus.InstrPC    = bypass ? bus.IAddr  : q_pc[0];
  assign pop            = (count != 2'd0) && bus.InstrReady;
  assign push           = ack_ok && !(bypass && bus.InstrReady);
`else
  assign bus.InstrValid = (count != 2'd0);
  assign bus.Instr      = q_data[0];
  assign bus.InstrPC    = q_pc[0];
  assign pop            = (count != 2'd0) && bus.InstrReady;
  assign push           = ack_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      bus.IReq  <= 1'b0;
      bus.IAddr <= '0;
      q_data    <= '0;
      q_pc      <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state     <= WAIT;
          bus.IReq  <= 1'b1;
          bus.IAddr <= pc;
        end
        WAIT: if (bus.IAck) begin
          state    <= IDLE;
          bus.IReq <= 1'b0;
        end else if (bus.PCSrc) begin
          state <= DROP;
        end
        DROP: if (bus.IAck) begin
          state    <= IDLE;
          bus.IReq <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (bus.PCSrc)  pc <= redir_pc;
      else if (ack_ok) pc <= pc + 32'd4;

      // Flush wins over any same-cycle push/pop; a popped entry was already delivered.
      if (bus.PCSrc) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            q_data[count[0]] <= bus.IRData;
            q_pc[count[0]]   <= bus.IAddr;
            count            <= count + 2'd1;
          end
          2'b01: begin
            q_data[0] <= q_data[1];
            q_pc[0]   <= q_pc[1];
            count     <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              q_data[0] <= bus.IRData;
              q_pc[0]   <= bus.IAddr;
            end else begin
              q_data[0] <= q_data[1];
              q_pc[0]   <= q_pc[1];
              q_data[1] <= bus.IRData;
              q_pc[1]   <= bus.IAddr;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
